// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle processor: sequences fetch, decode,
// execute, memory and write-back over one shared ALU/regfile/memory.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ALUOp,
  output logic       err,
  output logic [3:0] state_dbg
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || MEM_TIMEOUT >= (2 ** CNT_W)) begin : g_bad_param
    $error("MEM_TIMEOUT must be 1..255 and fit in CNT_W bits");
  end

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_I     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_ERROR    = 4'd15
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b100101;
  localparam logic [5:0] OP_SUBI = 6'b100110;
  localparam logic [5:0] OP_MULI = 6'b101000;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             is_sw_q, is_sw_d;

  logic in_wait;
  logic mem_timeout;

  // The counter value is the number of wait cycles already spent; the
  // current cycle is the last allowed one when it equals MEM_TIMEOUT-1.
  assign in_wait     = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                       (state_q == S_MEM_WR);
  assign mem_timeout = in_wait && !mem_ready && (cnt_q >= CNT_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      is_sw_q <= is_sw_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    is_sw_d = is_sw_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (mem_timeout) state_d = S_ERROR;
      end
      S_DECODE: begin
        // opcode is only looked at here; LW vs SW is remembered for MEM_ADDR.
        case (opcode)
          OP_LW: begin
            state_d = S_MEM_ADDR;
            is_sw_d = 1'b0;
          end
          OP_SW: begin
            state_d = S_MEM_ADDR;
            is_sw_d = 1'b1;
          end
          OP_R:                     state_d = S_EXEC_R;
          OP_ADDI, OP_SUBI, OP_MULI: state_d = S_EXEC_I;
          OP_BEQ:                   state_d = S_BRANCH;
          OP_J:                     state_d = S_JUMP;
          default:                  state_d = S_ERROR;
        endcase
      end
      S_MEM_ADDR: state_d = is_sw_q ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)        state_d = S_MEM_WB;
        else if (mem_timeout) state_d = S_ERROR;
      end
      S_MEM_WR: begin
        if (mem_ready)        state_d = S_FETCH;
        else if (mem_timeout) state_d = S_ERROR;
      end
      S_EXEC_R: state_d = S_WB_R;
      S_EXEC_I: state_d = S_WB_I;
      S_MEM_WB, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (in_wait && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign err_d = err_q || (state_d == S_ERROR);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ALUOp         = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEM_ADDR, S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ALUOp     = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC_R: alu_src_a = 1'b1;
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_WB_I: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        ALUOp         = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: the driver pushes the expected
// state and control word for every cycle, the monitor pops and compares.
module tb_multicycle_control_fsm;

  localparam int TMO = 4;

  localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_MEM_ADDR = 4'd2,
                         ST_MEM_RD = 4'd3, ST_MEM_WB = 4'd4,  ST_MEM_WR = 4'd5,
                         ST_EXEC_R = 4'd6, ST_WB_R = 4'd7,    ST_EXEC_I = 4'd8,
                         ST_WB_I = 4'd9,   ST_BRANCH = 4'd10, ST_JUMP = 4'd11,
                         ST_ERROR = 4'd15;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b100101,
                         OP_SUBI = 6'b100110, OP_MULI = 6'b101000, OP_BAD = 6'b111111;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       err;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] st;
    ctrl_t      c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, err;
  logic [1:0] pc_source, alu_src_b, ALUOp;
  logic [3:0] state_dbg;

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb_q[$];
  bit   tie_ready = 1'b0;
  ctrl_t obs;

  multicycle_control_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ALUOp(ALUOp), .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                ALUOp, err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Control word each state must present, straight from the state table.
  function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic mr);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      ST_DECODE:   c.alu_src_b = 2'b11;
      ST_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b10; end
      ST_MEM_RD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      ST_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      ST_MEM_WR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      ST_EXEC_R:   c.alu_src_a = 1'b1;
      ST_WB_R:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      ST_EXEC_I:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b10; end
      ST_WB_I:     c.reg_write = 1'b1;
      ST_BRANCH:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
      ST_JUMP:     begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      ST_ERROR:    c.err = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  function automatic logic fill_mr();
    return tie_ready ? 1'b1 : 1'($urandom);
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  // One clock cycle: drive inputs at the falling edge and record what the DUT
  // must show during this cycle.
  task automatic step(input logic mr, input logic [3:0] st, input logic [5:0] op);
    exp_t e;
    @(negedge clk);
    rst       = 1'b0;
    mem_ready = mr;
    opcode    = op;
    e.st = st;
    e.c  = exp_ctrl(st, mr);
    sb_q.push_back(e);
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check($sformatf("state(exp %0d)", e.st), 32'(state_dbg), 32'(e.st));
      check($sformatf("ctrl(st %0d)", e.st), 32'(obs), 32'(e.c));
    end
  end

  task automatic fetch(input int waits, input logic [5:0] op);
    for (int i = 0; i < waits; i++) step(1'b0, ST_FETCH, rnd_op());
    step(1'b1, ST_FETCH, rnd_op());
    step(fill_mr(), ST_DECODE, op);
  endtask

  task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait);
    fetch(fwait, op);
    case (op)
      OP_R: begin
        step(fill_mr(), ST_EXEC_R, rnd_op());
        step(fill_mr(), ST_WB_R, rnd_op());
      end
      OP_ADDI, OP_SUBI, OP_MULI: begin
        step(fill_mr(), ST_EXEC_I, rnd_op());
        step(fill_mr(), ST_WB_I, rnd_op());
      end
      OP_LW: begin
        step(fill_mr(), ST_MEM_ADDR, rnd_op());
        for (int i = 0; i < mwait; i++) step(1'b0, ST_MEM_RD, rnd_op());
        step(1'b1, ST_MEM_RD, rnd_op());
        step(fill_mr(), ST_MEM_WB, rnd_op());
      end
      OP_SW: begin
        step(fill_mr(), ST_MEM_ADDR, rnd_op());
        for (int i = 0; i < mwait; i++) step(1'b0, ST_MEM_WR, rnd_op());
        step(1'b1, ST_MEM_WR, rnd_op());
      end
      OP_BEQ: step(fill_mr(), ST_BRANCH, rnd_op());
      OP_J:   step(fill_mr(), ST_JUMP, rnd_op());
      default: ;
    endcase
  endtask

  task automatic sit_in_error(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom), ST_ERROR, rnd_op());
  endtask

  // Async reset between clock edges; the next step releases it.
  task automatic pulse_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_reg_write"}, 32'(reg_write), 32'd0);
    check({tag, "_mem_read"}, 32'(mem_read), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b0;
    opcode    = 6'd0;
    #12;
    check("por_state", 32'(state_dbg), 32'd0);
    check("por_err", 32'(err), 32'd0);
    check("por_mem_read", 32'(mem_read), 32'd1);
    check("por_pc_write", 32'(pc_write), 32'd0);

    // Back-to-back instructions, memory always ready.
    tie_ready = 1'b1;
    run_instr(OP_R, 0, 0);
    run_instr(OP_ADDI, 0, 0);
    run_instr(OP_LW, 0, 0);
    run_instr(OP_SW, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);
    tie_ready = 1'b0;

    run_instr(OP_SUBI, 0, 0);
    run_instr(OP_MULI, 1, 0);
    run_instr(OP_LW, 0, 3);
    run_instr(OP_LW, 3, 3);
    run_instr(OP_SW, 1, 2);

    // Ready on exactly the last allowed fetch wait cycle.
    run_instr(OP_J, TMO - 1, 0);

    // Reset in the middle of WB_R.
    fetch(0, OP_R);
    step(fill_mr(), ST_EXEC_R, rnd_op());
    step(fill_mr(), ST_WB_R, rnd_op());
    pulse_reset("rst_wbr");

    // Fetch timeout: memory never answers.
    for (int i = 0; i < TMO; i++) step(1'b0, ST_FETCH, rnd_op());
    sit_in_error(4);
    pulse_reset("rst_err_fetch");

    // Load data timeout.
    fetch(0, OP_LW);
    step(fill_mr(), ST_MEM_ADDR, rnd_op());
    for (int i = 0; i < TMO; i++) step(1'b0, ST_MEM_RD, rnd_op());
    sit_in_error(3);
    pulse_reset("rst_err_mem");

    // Illegal opcode.
    fetch(0, OP_BAD);
    sit_in_error(3);
    pulse_reset("rst_err_op");

    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_R, 2, 0);

    @(negedge clk);
    #3;
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
